// File: rtl/fibonacci_checker.sv
// Receive-side monitor for a wrapping Fibonacci stream.
// It synchronises on a 0 sample, then checks each following valid sample
// against an internal model of the same recurrence. The model wraps to 0,1
// once the sum overflows WIDTH bits. The monitor reports lock,
// per-sample mismatch pulses, a saturating error count and period events.
// Every output is registered: a sample taken at edge N is reflected after edge N.

module fibonacci_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] number,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] period_count
);

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // A single-sample lock length means the sync 0 alone is enough to lock.
  localparam state_t     SYNC_TARGET = (LOCK_LEN == 1) ? LOCKED : SYNC;
  localparam logic [3:0] LOCK_LEN_C  = 4'(LOCK_LEN);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] exp_cur, exp_cur_nxt;
  logic [WIDTH-1:0] exp_prev, exp_prev_nxt;
  logic [3:0]       run, run_nxt;
  logic             locked_nxt;
  logic             mismatch_nxt;
  logic             wrap_nxt;
  logic [CNT_W-1:0] err_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic [2*WIDTH-1:0] model_step;

  // One step of the recurrence. The sum is one bit wider than the data so
  // overflow is visible. On overflow the model restarts the period at 0,1.
  // The result is packed as {next exp_cur, next exp_prev}.
  function automatic logic [2*WIDTH-1:0] fib_step(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] prev);
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + {1'b0, prev};
    if (sum[WIDTH]) begin
      fib_step = {WIDTH'(0), WIDTH'(1)};
    end else begin
      fib_step = {sum[WIDTH-1:0], cur};
    end
  endfunction

  // Increment that sticks at all-ones instead of rolling over.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      sat_inc = c;
    end else begin
      sat_inc = c + CNT_W'(1);
    end
  endfunction

  assign model_step = fib_step(exp_cur, exp_prev);

  // Next-state, model update and output decode for one valid sample.
  always_comb begin
    state_nxt    = state;
    exp_cur_nxt  = exp_cur;
    exp_prev_nxt = exp_prev;
    run_nxt      = run;
    mismatch_nxt = 1'b0;
    wrap_nxt     = 1'b0;
    err_nxt      = err_count;
    period_nxt   = period_count;

    if (in_valid) begin
      case (state)
        SEEK: begin
          // Non-zero samples carry no phase information here; wait for a 0.
          if (number == '0) begin
            exp_cur_nxt  = WIDTH'(1);
            exp_prev_nxt = WIDTH'(0);
            run_nxt      = 4'd1;
            state_nxt    = SYNC_TARGET;
          end
        end

        SYNC, LOCKED: begin
          if (number == exp_cur) begin
            exp_cur_nxt  = model_step[2*WIDTH-1:WIDTH];
            exp_prev_nxt = model_step[WIDTH-1:0];
            // An expected 0 marks the completion of a full period.
            if (exp_cur == '0) begin
              wrap_nxt   = 1'b1;
              period_nxt = period_count + CNT_W'(1);
            end
            if (state == SYNC) begin
              run_nxt = run + 4'd1;
              if (run_nxt >= LOCK_LEN_C) begin
                state_nxt = LOCKED;
              end
            end
          end else begin
            mismatch_nxt = 1'b1;
            err_nxt      = sat_inc(err_count);
            // A stray 0 is most likely the start of a new period, so it is
            // used to resynchronise straight away rather than dropping to SEEK.
            if (number == '0) begin
              exp_cur_nxt  = WIDTH'(1);
              exp_prev_nxt = WIDTH'(0);
              run_nxt      = 4'd1;
              state_nxt    = SYNC_TARGET;
            end else begin
              run_nxt   = 4'd0;
              state_nxt = SEEK;
            end
          end
        end

        default: begin
          state_nxt = SEEK;
          run_nxt   = 4'd0;
        end
      endcase
    end

    locked_nxt = (state_nxt == LOCKED);
  end

  // State, model and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SEEK;
      exp_cur      <= '0;
      exp_prev     <= WIDTH'(1);
      run          <= 4'd0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      wrap_pulse   <= 1'b0;
      err_count    <= '0;
      period_count <= '0;
    end else begin
      state        <= state_nxt;
      exp_cur      <= exp_cur_nxt;
      exp_prev     <= exp_prev_nxt;
      run          <= run_nxt;
      locked       <= locked_nxt;
      mismatch     <= mismatch_nxt;
      wrap_pulse   <= wrap_nxt;
      err_count    <= err_nxt;
      period_count <= period_nxt;
    end
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed bench for fibonacci_checker with WIDTH=8, LOCK_LEN=4, CNT_W=8.
// A table of {valid, number, expected outputs} records covers lock, wrap,
// idle gaps and both mismatch kinds. Hand-written sequences then cover
// period counting, error saturation and asynchronous reset.

module tb_fibonacci_checker;

  localparam int WIDTH    = 8;
  localparam int LOCK_LEN = 4;
  localparam int CNT_W    = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] number;
  logic             locked;
  logic             mismatch;
  logic             wrap_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] period_count;

  fibonacci_checker #(
    .WIDTH   (WIDTH),
    .LOCK_LEN(LOCK_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .number      (number),
    .locked      (locked),
    .mismatch    (mismatch),
    .wrap_pulse  (wrap_pulse),
    .err_count   (err_count),
    .period_count(period_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] n;
    logic       l;
    logic       m;
    logic       w;
    int         e;
    int         p;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fib[14]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

  function automatic void add(input logic v, input int n, input logic l,
                              input logic m, input logic w, input int e, input int p);
    vec_t r;
    r.v = v; r.n = 8'(n); r.l = l; r.m = m; r.w = w; r.e = e; r.p = p;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic l, input logic m, input logic w,
                         input int e, input int p);
    chk({tag, ".locked"},       int'(locked),       int'(l));
    chk({tag, ".mismatch"},     int'(mismatch),     int'(m));
    chk({tag, ".wrap_pulse"},   int'(wrap_pulse),   int'(w));
    chk({tag, ".err_count"},    int'(err_count),    e);
    chk({tag, ".period_count"}, int'(period_count), p);
  endtask

  // Drive one sample at the falling edge, then sample outputs just after the rising edge.
  task automatic step(input logic v, input int n);
    @(negedge clk);
    in_valid = v;
    number   = 8'(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps;
    reset    = 1'b0;
    in_valid = 1'b0;
    number   = '0;

    // Table: first period with lock after the 4th sample.
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 2, 1, 0, 0, 0, 0);
    for (int i = 4; i < 14; i++) add(1, fib[i], 1, 0, 0, 0, 0);
    // Wrap into the next period.
    add(1, 0, 1, 0, 1, 0, 1);
    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 1);
    // Idle gaps: garbage on number must be ignored, and no pulses appear.
    add(0, 99, 1, 0, 0, 0, 1);
    add(1, 2,  1, 0, 0, 0, 1);
    add(0, 0,  1, 0, 0, 0, 1);
    add(1, 3,  1, 0, 0, 0, 1);
    add(0, 7,  1, 0, 0, 0, 1);
    add(1, 5,  1, 0, 0, 0, 1);
    // 5 instead of 8: mismatch, drop to SEEK, later non-zero samples ignored.
    add(1, 5,  0, 1, 0, 1, 1);
    add(1, 13, 0, 0, 0, 1, 1);
    add(1, 21, 0, 0, 0, 1, 1);
    // Relock from a fresh 0; this sync 0 does not count as a period.
    add(1, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 1, 1);
    add(1, 2, 1, 0, 0, 1, 1);
    add(1, 3, 1, 0, 0, 1, 1);
    add(1, 5, 1, 0, 0, 1, 1);
    add(1, 8, 1, 0, 0, 1, 1);
    add(1, 13, 1, 0, 0, 1, 1);
    // 0 instead of 21: one mismatch, immediate resync, no wrap pulse.
    add(1, 0, 0, 1, 0, 2, 1);
    add(1, 1, 0, 0, 0, 2, 1);
    add(1, 1, 0, 0, 0, 2, 1);
    add(1, 2, 1, 0, 0, 2, 1);

    // Reset state, checked while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].n);
      chk_all($sformatf("vec%0d", i), vecs[i].l, vecs[i].m, vecs[i].w, vecs[i].e, vecs[i].p);
    end

    // Finish the current period, then run 30 full periods.
    for (int i = 4; i < 14; i++) step(1, fib[i]);
    wraps = 0;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 14; i++) begin
        step(1, fib[i]);
        if (wrap_pulse) wraps++;
        if (mismatch) begin
          chk("periods.mismatch", int'(mismatch), 0);
        end
      end
    end
    chk("periods.wrap_count", wraps, 30);
    chk_all("periods", 1, 0, 0, 2, 31);

    // Repeated zeros: the first matches the expected 0 and wraps. Each later
    // zero mismatches against the expected 1 and resyncs, so the count saturates.
    step(1, 0);
    chk_all("zero_wrap", 1, 0, 1, 2, 32);
    for (int i = 0; i < 300; i++) step(1, 0);
    chk_all("saturate", 0, 1, 0, 255, 32);

    // Relock from the resync state: 1,1,2 completes a run of four.
    step(1, 1);
    step(1, 1);
    step(1, 2);
    chk_all("relock", 1, 0, 0, 255, 32);
    step(1, 3);

    // Asynchronous reset mid-period, observed before the next clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // After reset a non-zero sample is ignored; a fresh 0 is needed.
    step(1, 5);
    chk_all("post_reset_seek", 0, 0, 0, 0, 0);
    step(1, 0);
    step(1, 1);
    step(1, 1);
    step(1, 2);
    chk_all("post_reset_lock", 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
